// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal FIFO, with optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        baud_tick,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t r_state, w_state_n;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DATA_BITS-1:0] r_data, w_data_n, w_head;
  logic [IW-1:0] r_idx, w_idx_n;
  logic [1:0] r_stop, w_stop_n, w_stop_inc;
  logic r_par, w_par_n, r_tx, w_tx_n, r_busy, w_busy_n, r_done, w_done_n;
  logic w_push, w_pop, w_nonempty;
  assign s_ready    = r_count != CW'(FIFO_DEPTH);
  assign w_push     = s_valid && s_ready;
  assign w_nonempty = r_count != '0;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_stop_inc = r_stop + 2'd1;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_done;
  assign fifo_count = r_count;
  // r_data shifts right so the next bit to send is always bit 0; parity is latched at pop time
  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_par_n   = r_par;
    w_idx_n   = r_idx;
    w_stop_n  = r_stop;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_pop     = 1'b0;
    if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          w_pop     = w_nonempty;
          w_tx_n    = !w_nonempty;
          w_busy_n  = w_nonempty;
          w_state_n = w_nonempty ? S_START : S_IDLE;
        end
        S_START: begin
          w_tx_n    = r_data[0];
          w_data_n  = r_data >> 1;
          w_idx_n   = IW'(1);
          w_state_n = S_DATA;
        end
        S_DATA: begin
          if (r_idx == IW'(DATA_BITS)) begin
            w_tx_n    = (PARITY != 0) ? r_par : 1'b1;
            w_stop_n  = '0;
            w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_tx_n   = r_data[0];
            w_data_n = r_data >> 1;
            w_idx_n  = r_idx + IW'(1);
          end
        end
        S_PAR: begin
          w_tx_n    = 1'b1;
          w_stop_n  = '0;
          w_state_n = S_STOP;
        end
        S_STOP: begin
          w_stop_n = w_stop_inc;
          if (w_stop_inc == 2'(STOP_BITS)) begin
            w_done_n  = 1'b1;
            w_pop     = w_nonempty;
            w_tx_n    = !w_nonempty;
            w_busy_n  = w_nonempty;
            w_state_n = w_nonempty ? S_START : S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
      if (w_pop) begin
        w_data_n = w_head;
        w_par_n  = (PARITY == 2) ? ^w_head : ~^w_head;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_idx    <= '0;
      r_stop   <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_data   <= w_data_n;
      r_par    <= w_par_n;
      r_idx    <= w_idx_n;
      r_stop   <= w_stop_n;
      r_tx     <= w_tx_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three configurations of uart_tx_fifo checked every cycle against a frame-list model.
module tb_uart_tx_fifo;
  logic clk = 0, reset = 0, baud_tick = 0, s_valid = 0;
  logic [7:0] sd = '0;
  logic [2:0] tx_w, busy_w, done_w, ready_w;
  logic [2:0][3:0] cnt_w;
  logic [2:0][15:0] cap;
  int dtk[3];
  int checks = 0, passes = 0;
  bit chk_on = 0;
  bit seen_done;
  int per, vp;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int DB = g == 2 ? 5 : 8;
    localparam int PA = g == 0 ? 0 : g == 1 ? 2 : 1;
    localparam int SB = g == 1 ? 2 : 1;
    localparam int FD = g == 0 ? 8 : g == 1 ? 4 : 2;
    logic w_tx, w_busy, w_done, w_rdy;
    logic [$clog2(FD):0] w_cnt;
    logic [DB-1:0] mq[$];
    logic [DB-1:0] hw;
    bit fr[$];
    bit m_tx = 1, m_busy = 0, m_done = 0, push;
    uart_tx_fifo #(.DATA_BITS(DB), .PARITY(PA), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .s_data(sd[DB-1:0]), .s_valid(s_valid),
      .s_ready(w_rdy), .tx(w_tx), .busy(w_busy), .tx_done(w_done), .fifo_count(w_cnt));
    assign tx_w[g]    = w_tx;
    assign busy_w[g]  = w_busy;
    assign done_w[g]  = w_done;
    assign ready_w[g] = w_rdy;
    assign cnt_w[g]   = 4'(w_cnt);
    // model: a word becomes a list of line levels; each tick consumes one, an empty list ends the frame
    always @(posedge clk) begin
      if (!reset) begin
        mq.delete();
        fr.delete();
        m_tx = 1;
        m_busy = 0;
        m_done = 0;
      end else begin
        push = s_valid && (mq.size() != FD);
        m_done = 0;
        if (baud_tick) begin
          if (m_busy && fr.size() != 0) m_tx = fr.pop_front();
          else begin
            m_done = m_busy;
            m_busy = mq.size() != 0;
            m_tx = 1;
            if (m_busy) begin
              hw = mq.pop_front();
              fr.push_back(0);
              for (int i = 0; i < DB; i++) fr.push_back(hw[i]);
              if (PA != 0) fr.push_back(PA == 2 ? ^hw : ~^hw);
              for (int i = 0; i < SB; i++) fr.push_back(1);
              m_tx = fr.pop_front();
            end
          end
        end
        if (push) mq.push_back(sd[DB-1:0]);
      end
    end
    always @(negedge clk) begin
      if (chk_on) begin
        chk($sformatf("u%0d tx", g), int'(w_tx), int'(m_tx));
        chk($sformatf("u%0d busy", g), int'(w_busy), int'(m_busy));
        chk($sformatf("u%0d tx_done", g), int'(w_done), int'(m_done));
        chk($sformatf("u%0d fifo_count", g), int'(w_cnt), mq.size());
        chk($sformatf("u%0d s_ready", g), int'(w_rdy), int'(mq.size() != FD));
      end
    end
  end
  task automatic cap_word(input logic [7:0] w, input int n);
    @(negedge clk);
    sd = w;
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    cap = '0;
    for (int i = 0; i < 3; i++) dtk[i] = -1;
    for (int k = 0; k < n; k++) begin
      repeat (15) @(negedge clk);
      baud_tick = 1;
      @(negedge clk);
      baud_tick = 0;
      for (int i = 0; i < 3; i++) begin
        cap[i][k] = tx_w[i];
        if (done_w[i]) dtk[i] = k;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    chk_on = 1;
    @(negedge clk);
    chk("reset tx", int'(tx_w), 7);
    chk("reset busy", int'(busy_w), 0);
    chk("reset s_ready", int'(ready_w), 7);
    chk("reset count", int'(cnt_w), 0);
    cap_word(8'hA5, 14);
    chk("A5 line u0", int'(cap[0][9:0]), 'b1101001010);
    chk("A5 line u1", int'(cap[1][11:0]), 'b110101001010);
    chk("A5 line u2", int'(cap[2][7:0]), 'b11001010);
    chk("frame len u0", dtk[0], 10);
    chk("frame len u1", dtk[1], 12);
    chk("frame len u2", dtk[2], 8);
    chk("idle after frame", int'(busy_w), 0);
    cap_word(8'h07, 14);
    chk("even parity u1", int'(cap[1][9]), 1);
    chk("odd parity u2", int'(cap[2][6]), 0);
    repeat (10) begin
      @(negedge clk);
      s_valid = 1;
      sd = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 0;
    chk("full count u0", int'(cnt_w[0]), 8);
    chk("full count u1", int'(cnt_w[1]), 4);
    chk("full count u2", int'(cnt_w[2]), 2);
    chk("full s_ready", int'(ready_w), 0);
    baud_tick = 1;
    @(negedge clk);
    baud_tick = 0;
    chk("ready after pop", int'(ready_w), 7);
    chk("count after pop u1", int'(cnt_w[1]), 3);
    for (int s = 0; s < 8; s++) begin
      per = (s % 4 == 0) ? 1 : $urandom_range(2, 12);
      vp = $urandom_range(1, 4);
      repeat (500) begin
        @(negedge clk);
        baud_tick = ($urandom_range(1, per) == 1);
        s_valid = ($urandom_range(1, vp) == 1);
        sd = 8'($urandom);
      end
    end
    @(negedge clk);
    s_valid = 0;
    baud_tick = 1;
    repeat (300) @(negedge clk);
    baud_tick = 0;
    repeat (3) begin
      s_valid = 1;
      sd = 8'($urandom);
      @(negedge clk);
    end
    s_valid = 0;
    baud_tick = 1;
    for (int i = 0; i < 50 && busy_w[0] == 0; i++) @(negedge clk);
    chk("busy before reset", int'(busy_w[0]), 1);
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("mid reset tx", int'(tx_w), 7);
    chk("mid reset busy", int'(busy_w), 0);
    chk("mid reset done", int'(done_w), 0);
    chk("mid reset count", int'(cnt_w), 0);
    seen_done = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_w != 0 || tx_w != 3'b111) seen_done = 1;
    end
    chk("quiet after reset", int'(seen_done), 0);
    baud_tick = 1;
    s_valid = 1;
    sd = 8'h3C;
    @(negedge clk);
    baud_tick = 0;
    s_valid = 0;
    chk("coincident tick no start", int'(busy_w), 0);
    baud_tick = 1;
    @(negedge clk);
    baud_tick = 0;
    chk("start after push", int'(tx_w), 0);
    chk("busy after start", int'(busy_w), 7);
    baud_tick = 1;
    repeat (40) @(negedge clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
